// File: rtl/gravsim_datafile.sv
// Simulation datafile for the physics FSM: host port, FSM triple-write
// port and the timestep start/done handshake with status and counter.
module gravsim_datafile #(
  parameter int WORDS     = 113,
  parameter int AW        = 7,
  parameter int STEP_ADDR = 126,
  parameter int CTRL_ADDR = 127
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   AVL_CS,
  input  logic                   AVL_READ,
  input  logic                   AVL_WRITE,
  input  logic [AW-1:0]          AVL_ADDR,
  input  logic [3:0]             AVL_BYTE_EN,
  input  logic [31:0]            AVL_WRITEDATA,
  output logic [31:0]            AVL_READDATA,
  output logic [WORDS-1:0][31:0] datafile,
  output logic                   FSM_START,
  input  logic                   FSM_DONE,
  input  logic [1:0]             FSM_we,
  input  logic [31:0]            ADDR1,
  input  logic [31:0]            ADDR2,
  input  logic [31:0]            ADDR3,
  input  logic [31:0]            DATA1,
  input  logic [31:0]            DATA2,
  input  logic [31:0]            DATA3,
  output logic                   IRQ
);

  localparam logic [AW-1:0] WordsA = AW'(WORDS);
  localparam logic [AW-1:0] StepA  = AW'(STEP_ADDR);
  localparam logic [AW-1:0] CtrlA  = AW'(CTRL_ADDR);
  localparam logic [31:0]   WordsD = 32'(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state, stateNext;

  logic        hostWr, hostRd;
  logic        ctrlWr, dataWr;
  logic        busy, doneEvt, fsmWr;
  logic        done, err;
  logic [15:0] stepCnt;
  logic [31:0] rdData;

  assign hostWr = AVL_CS & AVL_WRITE;
  assign hostRd = AVL_CS & AVL_READ;
  assign ctrlWr = hostWr && (AVL_ADDR == CtrlA);
  assign dataWr = hostWr && (AVL_ADDR < WordsA);
  assign fsmWr  = busy && (FSM_we == 2'd1);

  // Timestep control state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= stateNext;
  end

  // Next state, handshake output and completion event
  always_comb begin
    stateNext = state;
    FSM_START = 1'b0;
    doneEvt   = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (ctrlWr && AVL_WRITEDATA[0]) stateNext = RUN;
      end
      RUN: begin
        FSM_START = 1'b1;
        if (FSM_DONE) stateNext = ACK;
      end
      ACK: begin
        if (!FSM_DONE) begin
          stateNext = IDLE;
          doneEvt   = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Sticky status flags, step counter and completion pulse
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      done    <= 1'b0;
      err     <= 1'b0;
      stepCnt <= '0;
      IRQ     <= 1'b0;
    end else begin
      IRQ <= doneEvt;
      if (doneEvt) begin
        done    <= 1'b1;
        stepCnt <= stepCnt + 16'd1;
      end else if (ctrlWr && AVL_WRITEDATA[1]) begin
        done <= 1'b0;
      end
      if (dataWr && busy)
        err <= 1'b1;
      else if (ctrlWr && AVL_WRITEDATA[3])
        err <= 1'b0;
    end
  end

  // Datafile: host byte writes when idle, FSM lane writes when busy
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      datafile <= '0;
    end else begin
      if (dataWr && !busy) begin
        for (int b = 0; b < 4; b++)
          if (AVL_BYTE_EN[b])
            datafile[AVL_ADDR][8*b +: 8] <=
              AVL_WRITEDATA[8*b +: 8];
      end
      if (fsmWr) begin
        if (ADDR1 < WordsD)
          datafile[ADDR1[AW-1:0]] <= DATA1;
        if (ADDR2 < WordsD)
          datafile[ADDR2[AW-1:0]] <= DATA2;
        if (ADDR3 < WordsD)
          datafile[ADDR3[AW-1:0]] <= DATA3;
      end
    end
  end

  // Host read decode
  always_comb begin
    rdData = '0;
    unique case (1'b1)
      (AVL_ADDR < WordsA): rdData = datafile[AVL_ADDR];
      (AVL_ADDR == StepA): rdData = {16'h0, stepCnt};
      (AVL_ADDR == CtrlA):
        rdData = {28'h0, err, busy, done, 1'b0};
      default: rdData = '0;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      AVL_READDATA <= '0;
    else if (hostRd) AVL_READDATA <= rdData;
  end

endmodule

// File: doc/gravsim_datafile.md
Name: gravsim_datafile

Overview:
Responder end of the physics FSM's write interface: owns the 113-word, 32-bit simulation datafile and presents it to the FSM as a flat array. It accepts the FSM's triple-write bus (FSM_we, ADDR1-3, DATA1-3) and drives the FSM_START/FSM_DONE timestep handshake. It exposes an Avalon-MM slave so the host CPU can load planet data, launch timesteps and read back results.

Parameters:
WORDS, 113, number of 32-bit datafile words (host addresses 0..WORDS-1)
AW, 7, host address width
STEP_ADDR, 126, host address of the read-only timestep counter
CTRL_ADDR, 127, host address of the control/status register

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
AVL_CS  in  1  host chip select
AVL_READ  in  1  host read strobe
AVL_WRITE  in  1  host write strobe
AVL_ADDR  in  AW  host word address
AVL_BYTE_EN  in  4  host write byte enables
AVL_WRITEDATA  in  32  host write data
AVL_READDATA  out  32  host read data, registered
datafile  out  32 x WORDS  current datafile contents to the FSM
FSM_START  out  1  timestep request to the FSM
FSM_DONE  in  1  timestep complete from the FSM
FSM_we  in  2  FSM write enable code
ADDR1, ADDR2, ADDR3  in  32  FSM write addresses
DATA1, DATA2, DATA3  in  32  FSM write data
IRQ  out  1  one-cycle pulse on timestep completion

Behaviour:
- Reset (RESET low, asynchronous): all datafile words 0; FSM_START 0; AVL_READDATA 0; IRQ 0; step counter 0; DONE and ERR flags 0; control FSM in IDLE. Reset asserted mid-timestep aborts immediately. FSM_START drops without waiting for FSM_DONE.
- Control FSM:
  - IDLE: FSM_START=0. A host write to CTRL_ADDR with bit0=1 goes to RUN on the next edge.
  - RUN: FSM_START=1. FSM_DONE=1 goes to ACK.
  - ACK: FSM_START=0. FSM_DONE=0 goes to IDLE. On that transition: DONE sticky set, step counter +1, IRQ high for exactly one cycle.
  - BUSY = (state != IDLE).
- Control/status register, CTRL_ADDR:
  - Read: bit0 0; bit1 DONE; bit2 BUSY; bit3 ERR; others 0.
  - Write: bit0 START, ignored while BUSY (no ERR). bit1 and bit3 are write-1-to-clear. Byte enables are ignored for this register.
  - If START and the DONE-set event occur in the same cycle, DONE set wins and START is ignored.
- Step counter, STEP_ADDR: 16 bits, zero-extended on read, wraps 0xFFFF->0x0000. Host writes are ignored.
- Host datafile write (AVL_CS&AVL_WRITE, addr<WORDS):
  - Byte-enabled; data is visible on datafile the next cycle.
  - While BUSY the write is dropped and ERR is set.
  - Writes to unmapped addresses (WORDS..125) are dropped silently.
- Host read (AVL_CS&AVL_READ): AVL_READDATA updates one cycle after the strobe and holds until the next read. Unmapped addresses read 0. Reads are allowed while BUSY.
- FSM writes:
  - Accepted only in RUN or ACK; ignored in IDLE.
  - FSM_we==1: writes DATA1/2/3 to ADDR1/2/3 in the same cycle. Codes 2 and 3 are reserved and ignored.
  - Any ADDRn >= WORDS drops that lane only.
  - Duplicate addresses: ADDR3 over ADDR2 over ADDR1.
  - Written data is visible on datafile and to host reads the next cycle.
- Host writes and FSM writes never collide: host datafile writes are blocked whenever FSM writes are accepted.

Test Plan:
1. Reset, then host writes 0x3F800000 to addr 23 with BYTE_EN=F and reads it back -> AVL_READDATA=0x3F800000 one cycle after the read strobe; datafile[23]=0x3F800000.
2. Write CTRL bit0 -> FSM_START=1 next cycle. Hold FSM_DONE=1 -> FSM_START=0. Drop FSM_DONE -> IRQ pulses one cycle; CTRL reads 0x2; STEP_ADDR reads 1.
3. In RUN, FSM_we=1 with ADDR1=53, ADDR2=63, ADDR3=53 and DATA=0xA,0xB,0xC -> datafile[53]=0xC, datafile[63]=0xB. The same stimulus in IDLE leaves the datafile unchanged.
4. In RUN, host writes 0x12345678 to addr 3 -> write dropped, CTRL bit3=1. Writing 0x8 to CTRL -> ERR clears.
5. Preload the step counter to 0xFFFF by running 65535 timesteps (or force) and complete one more -> STEP_ADDR reads 0.
6. Pull RESET low during RUN -> FSM_START=0 asynchronously, all datafile words 0, CTRL reads 0.
